// File: rtl/wi23_defs.sv
// Shared WI23 core constants.
package wi23_defs;
  localparam int unsigned IMEM_DEPTH = 8;
endpackage

// File: rtl/imem_arb.sv
// Single-port instruction memory arbiter: CPU fetch vs host loader/debug port.
// Host wins by default; a starve counter forces a periodic fetch grant unless the host holds the lock.
module imem_arb #(
  parameter int unsigned IMEM_DEPTH = wi23_defs::IMEM_DEPTH,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_i,
  input  logic [IMEM_DEPTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_vld_o,
  output logic [15:0]           fetch_inst_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [IMEM_DEPTH-1:0] host_addr_i,
  input  logic [15:0]           host_wdata_i,
  input  logic                  host_lock_i,
  output logic                  host_gnt_o,
  output logic                  host_vld_o,
  output logic [15:0]           host_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [IMEM_DEPTH-1:0] mem_addr_o,
  output logic [15:0]           mem_wdata_o,
  input  logic [15:0]           mem_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic        force_fetch;
  logic        fetch_gnt;
  logic        host_gnt;
  logic        tag_fetch;
  logic        tag_host;
  logic [15:0] fetch_hold;
  logic [15:0] host_hold;

  always_comb begin
    force_fetch = 1'b0;
    host_gnt    = 1'b0;
    fetch_gnt   = 1'b0;
    if (!rst) begin
      force_fetch = fetch_req_i && !host_lock_i && (starve_cnt == STARVE_LIM);
      host_gnt    = host_req_i && !force_fetch;
      fetch_gnt   = fetch_req_i && !host_lock_i && (!host_req_i || force_fetch);
    end
  end

  assign fetch_gnt_o = fetch_gnt;
  assign host_gnt_o  = host_gnt;
  assign mem_en_o    = fetch_gnt | host_gnt;
  assign mem_we_o    = host_gnt & host_we_i;
  assign mem_addr_o  = host_gnt ? host_addr_i : fetch_addr_i;
  assign mem_wdata_o = host_wdata_i;

  // Memory data arrives one cycle after the grant, so the valid cycle shows it
  // straight through; the hold registers keep it afterwards. Reset drops a pending response.
  assign fetch_vld_o  = tag_fetch & ~rst;
  assign host_vld_o   = tag_host & ~rst;
  assign fetch_inst_o = fetch_vld_o ? mem_rdata_i : fetch_hold;
  assign host_rdata_o = host_vld_o ? mem_rdata_i : host_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      tag_fetch  <= 1'b0;
      tag_host   <= 1'b0;
      fetch_hold <= '0;
      host_hold  <= '0;
    end else begin
      if (host_lock_i || !fetch_req_i || fetch_gnt)
        starve_cnt <= '0;
      else
        starve_cnt <= starve_cnt + 4'd1;
      tag_fetch <= fetch_gnt;
      tag_host  <= host_gnt & ~host_we_i;
      if (tag_fetch)
        fetch_hold <= mem_rdata_i;
      if (tag_host)
        host_hold <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Directed + random bench for imem_arb with a synchronous memory model and response scoreboards.
module tb_imem_arb;
  localparam int AW = wi23_defs::IMEM_DEPTH;
  localparam int MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt, fetch_vld;
  logic [15:0]   fetch_inst;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [15:0]   host_wdata;
  logic          host_gnt, host_vld;
  logic [15:0]   host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  imem_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_vld_o(fetch_vld), .fetch_inst_o(fetch_inst),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_lock_i(host_lock), .host_gnt_o(host_gnt),
    .host_vld_o(host_vld), .host_rdata_o(host_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'((i * 257) ^ 16'h1357);
  endfunction

  // Synchronous single-port memory: read data appears the cycle after the strobe.
  logic [15:0] mem [0:MW-1];
  logic        preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_val(i);
      mem[16] <= 16'hA5A5;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] data; } resp_t;
  resp_t fq[$];
  resp_t hq[$];

  logic [15:0] shadow [0:MW-1];
  logic [3:0]  m_cnt = '0;
  logic [15:0] last_f = '0;
  logic [15:0] last_h = '0;
  bit          started = 1'b0;
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboards when a response is due.
  always @(negedge clk) begin
    if (started) begin
      bit ev;
      ev = !rst && fq.size() > 0 && fq[0].due == cyc;
      chk("fetch_vld", 16'(fetch_vld), 16'(ev));
      if (ev) begin
        chk("fetch_inst", fetch_inst, fq[0].data);
        last_f = fq[0].data;
        void'(fq.pop_front());
      end else begin
        chk("fetch_hold", fetch_inst, last_f);
      end
      ev = !rst && hq.size() > 0 && hq[0].due == cyc;
      chk("host_vld", 16'(host_vld), 16'(ev));
      if (ev) begin
        chk("host_rdata", host_rdata, hq[0].data);
        last_h = hq[0].data;
        void'(hq.pop_front());
      end else begin
        chk("host_hold", host_rdata, last_h);
      end
      if (rst) begin
        while (fq.size() > 0 && fq[0].due <= cyc) void'(fq.pop_front());
        while (hq.size() > 0 && hq[0].due <= cyc) void'(hq.pop_front());
        last_f = '0;
        last_h = '0;
      end
    end
  end

  task automatic step(input logic r, input logic fr, input logic [AW-1:0] fa,
                      input logic hr, input logic hw, input logic [AW-1:0] ha,
                      input logic [15:0] hd, input logic lk);
    logic frc, ef, eh;
    rst = r; fetch_req = fr; fetch_addr = fa; host_req = hr; host_we = hw;
    host_addr = ha; host_wdata = hd; host_lock = lk;
    @(negedge clk);
    frc = !r && fr && !lk && (m_cnt == 4'd4);
    eh  = !r && hr && !frc;
    ef  = !r && fr && !lk && (!hr || frc);
    chk("fetch_gnt", 16'(fetch_gnt), 16'(ef));
    chk("host_gnt", 16'(host_gnt), 16'(eh));
    chk("mem_en", 16'(mem_en), 16'(ef | eh));
    chk("mem_we", 16'(mem_we), 16'(eh & hw));
    if (eh) begin
      chk("mem_addr_host", 16'(mem_addr), 16'(ha));
      if (hw) begin
        chk("mem_wdata", mem_wdata, hd);
        shadow[ha] = hd;
      end else begin
        hq.push_back('{cyc + 1, shadow[ha]});
      end
    end
    if (ef) begin
      chk("mem_addr_fetch", 16'(mem_addr), 16'(fa));
      fq.push_back('{cyc + 1, shadow[fa]});
    end
    if (r || lk || !fr || ef) m_cnt = '0;
    else                      m_cnt = m_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) shadow[i] = init_val(i);
    shadow[16] = 16'hA5A5;
    preload = 1'b1;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    preload = 1'b0;
    started = 1'b1;
    step(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h01, '0, 1'b0);

    // Fetch alone at 0x010
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, '0, '0, 1'b0);
    idle();
    idle();

    // Host write 0x1234 to 0x003, then read it back
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h03, 16'h1234, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h03, '0, 1'b0);
    idle();

    // Host write followed immediately by a fetch of the same word
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, '0, '0, 1'b0);
    idle();

    // Both requesting continuously: four host grants then a forced fetch
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, AW'(8'h40 + i), '0, 1'b0);

    // Fetch drop clears the counter
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, AW'(8'h50 + i), '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h55, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, AW'(8'h60 + i), 1'b1, 1'b0, AW'(i), '0, 1'b0);

    // Lock blocks fetches; release grants the same cycle
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h12, '0, 1'b1);
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, '0, '0, 1'b0);
    // In-flight fetch still completes after lock asserts
    step(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, '0, '0, 1'b1);
    idle();

    // Reset during a pending fetch response
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, '0, '0, 1'b0);
    idle();
    // Reset mid-starvation restarts the count
    step(1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 8'h22, '0, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 8'h22, '0, 1'b0);
    step(1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 8'h22, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 8'h22, '0, 1'b0);

    // Random mix over a small address window
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           16'($urandom), 1'($urandom_range(0, 7) == 0));

    idle();
    idle();
    chk("queue_drain", 16'(fq.size() + hq.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
